// File: rtl/combi_pkg.sv
// combi_pkg: shared types and decode constants for the combined ARM/RISC-V
// decode queue.
//   isa_mode_t     : ISA mode encoding (MODE_RV, MODE_ARM)
//   RV_*           : RISC-V opcode / funct3 / funct7 values accepted by the decoder
//   ARM_*          : ARM Op / data-processing command / condition values
//   rv_alu_f3_ok() : funct3 values implemented by the RISC-V ALU table
package combi_pkg;

  typedef enum logic {
    MODE_RV  = 1'b0,
    MODE_ARM = 1'b1
  } isa_mode_t;

  // RISC-V main decoder opcodes
  localparam logic [6:0] RV_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] RV_OP_STORE  = 7'b0100011;
  localparam logic [6:0] RV_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] RV_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] RV_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] RV_OP_JAL    = 7'b1101111;
  localparam logic [6:0] RV_OP_LUI    = 7'b0110111;

  // RISC-V funct3 / funct7 values
  localparam logic [2:0] RV_F3_ADD = 3'b000;
  localparam logic [2:0] RV_F3_SLT = 3'b010;
  localparam logic [2:0] RV_F3_OR  = 3'b110;
  localparam logic [2:0] RV_F3_AND = 3'b111;
  localparam logic [2:0] RV_F3_LW  = 3'b010;
  localparam logic [2:0] RV_F3_SW  = 3'b010;
  localparam logic [2:0] RV_F3_BEQ = 3'b000;
  localparam logic [6:0] RV_F7_BASE = 7'b0000000;
  localparam logic [6:0] RV_F7_ALT  = 7'b0100000;

  // ARM Op field (instr[27:26]) and implemented data-processing commands
  localparam logic [1:0] ARM_OP_DP  = 2'b00;
  localparam logic [1:0] ARM_OP_MEM = 2'b01;
  localparam logic [1:0] ARM_OP_BR  = 2'b10;
  localparam logic [3:0] ARM_CMD_AND = 4'b0000;
  localparam logic [3:0] ARM_CMD_SUB = 4'b0010;
  localparam logic [3:0] ARM_CMD_ADD = 4'b0100;
  localparam logic [3:0] ARM_CMD_ORR = 4'b1100;
  localparam logic [3:0] ARM_COND_NV = 4'b1111;

  function automatic logic rv_alu_f3_ok(input logic [2:0] f3);
    logic ok;
    case (f3)
      RV_F3_ADD, RV_F3_SLT, RV_F3_OR, RV_F3_AND: ok = 1'b1;
      default:                                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/combi_isa_classify.sv
// combi_isa_classify: combinational validity check of one instruction word
// against the RISC-V and ARM decode tables of the combined decoder.
//   instr    in  XLEN  instruction word (low 32 bits are decoded)
//   rvValid  out 1     instruction is implemented by the RISC-V decoder
//   armValid out 1     instruction is implemented by the ARM decoder
module combi_isa_classify
  import combi_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] instr,
  output logic            rvValid,
  output logic            armValid
);

  logic [6:0] rv_opcode_s;
  logic [2:0] rv_f3_s;
  logic [6:0] rv_f7_s;
  logic [3:0] arm_cond_s;
  logic [1:0] arm_op_s;
  logic [3:0] arm_cmd_s;
  logic       unused_s;

  assign rv_opcode_s = instr[6:0];
  assign rv_f3_s     = instr[14:12];
  assign rv_f7_s     = instr[31:25];
  assign arm_cond_s  = instr[31:28];
  assign arm_op_s    = instr[27:26];
  assign arm_cmd_s   = instr[24:21];
  // register-number fields do not affect legality
  assign unused_s    = ^{instr[XLEN-1:32-1+1-1+1-1], instr[20:15], instr[11:7]};

  // RISC-V: main decoder opcode table, narrowed by the ALU funct table
  always_comb begin
    rvValid = 1'b0;
    case (rv_opcode_s)
      RV_OP_LOAD:   rvValid = (rv_f3_s == RV_F3_LW);
      RV_OP_STORE:  rvValid = (rv_f3_s == RV_F3_SW);
      RV_OP_RTYPE:  rvValid = ((rv_f7_s == RV_F7_BASE) && rv_alu_f3_ok(rv_f3_s)) ||
                              ((rv_f7_s == RV_F7_ALT) && (rv_f3_s == RV_F3_ADD));
      RV_OP_ITYPE:  rvValid = rv_alu_f3_ok(rv_f3_s);
      RV_OP_BRANCH: rvValid = (rv_f3_s == RV_F3_BEQ);
      RV_OP_JAL:    rvValid = 1'b1;
      RV_OP_LUI:    rvValid = 1'b1;
      default:      rvValid = 1'b0;
    endcase
  end

  // ARM: data-processing restricted to the implemented ALU commands,
  // word LDR/STR without writeback, and B; the NV condition is never legal
  always_comb begin
    armValid = 1'b0;
    if (arm_cond_s == ARM_COND_NV) begin
      armValid = 1'b0;
    end else begin
      case (arm_op_s)
        ARM_OP_DP: begin
          case (arm_cmd_s)
            ARM_CMD_AND, ARM_CMD_SUB, ARM_CMD_ADD, ARM_CMD_ORR: armValid = 1'b1;
            default:                                            armValid = 1'b0;
          endcase
        end
        ARM_OP_MEM: armValid = (instr[22] == 1'b0) && (instr[21] == 1'b0);
        ARM_OP_BR:  armValid = (instr[25] == 1'b1);
        default:    armValid = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/combi_decode_queue.sv
// combi_decode_queue: instruction FIFO between fetch and the combined
// ARM/RISC-V decode stage. Tags the head entry with its ISA, flags entries
// illegal in both ISAs, tracks the ISA mode and counts mode switches.
// Optional feature macro: COMBI_MODE_LOCK_EN (adds modeLock input).
//   clk, reset                 : clock, synchronous active-high reset
//   instrF, pcF, validF/readyF : fetch-side push handshake
//   instrD, pcD, validD/readyD : decode-side head and pop handshake
//   armD, illegalD, modeSwitchD: head classification
//   flushD, flushArm           : empty the queue and load the mode
//   modeLock (optional)        : hold the current mode, no automatic switch
//   occupancy, switchCount     : entries held, saturating switch counter
module combi_decode_queue
  import combi_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 4,
  parameter int RESET_ARM = 0,
  parameter int CNT_W     = 16,
  localparam int OCC_W    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  instrF,
  input  logic [XLEN-1:0]  pcF,
  input  logic             validF,
  output logic             readyF,
  output logic [XLEN-1:0]  instrD,
  output logic [XLEN-1:0]  pcD,
  output logic             validD,
  input  logic             readyD,
  output logic             armD,
  output logic             illegalD,
  output logic             modeSwitchD,
  input  logic             flushD,
  input  logic             flushArm,
`ifdef COMBI_MODE_LOCK_EN
  input  logic             modeLock,
`endif
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] switchCount
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam isa_mode_t RESET_MODE = (RESET_ARM != 0) ? MODE_ARM : MODE_RV;
  localparam logic [OCC_W-1:0] FULL_C = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

  logic [XLEN-1:0]  instr_mem_r [DEPTH];
  logic [XLEN-1:0]  pc_mem_r    [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [OCC_W-1:0] occ_r;
  logic [CNT_W-1:0] cnt_r;
  isa_mode_t        mode_r;
  isa_mode_t        mode_next_s;

  logic push_s;
  logic pop_s;
  logic valid_s;
  logic ready_s;
  logic lock_s;
  logic mode_arm_s;
  logic rv_valid_s;
  logic arm_valid_s;
  logic arm_raw_s;
  logic arm_s;
  logic illegal_s;
  logic switch_s;

`ifdef COMBI_MODE_LOCK_EN
  assign lock_s = modeLock;
`else
  assign lock_s = 1'b0;
`endif

  assign valid_s    = (occ_r != {OCC_W{1'b0}});
  assign ready_s    = (occ_r < FULL_C) & ~flushD;
  assign push_s     = validF & ready_s;
  assign pop_s      = valid_s & readyD;
  assign mode_arm_s = (mode_r == MODE_ARM);

  combi_isa_classify #(.XLEN(XLEN)) u_classify (
    .instr    (instr_mem_r[head_r]),
    .rvValid  (rv_valid_s),
    .armValid (arm_valid_s)
  );

  // Head ISA tag and legality; an empty queue reports the current mode
  always_comb begin
    arm_raw_s = mode_arm_s;
    illegal_s = 1'b0;
    if (lock_s) begin
      arm_raw_s = mode_arm_s;
      illegal_s = valid_s & ~(mode_arm_s ? arm_valid_s : rv_valid_s);
    end else begin
      case ({rv_valid_s, arm_valid_s})
        2'b10:   arm_raw_s = 1'b0;
        2'b01:   arm_raw_s = 1'b1;
        default: arm_raw_s = mode_arm_s;
      endcase
      illegal_s = valid_s & ~rv_valid_s & ~arm_valid_s;
    end
    if (valid_s) begin
      arm_s = arm_raw_s;
    end else begin
      arm_s = mode_arm_s;
    end
  end

  assign switch_s = valid_s & (arm_s != mode_arm_s);

  // Entry storage; data words need no reset since validD qualifies them
  always_ff @(posedge clk) begin
    if (push_s) begin
      instr_mem_r[tail_r] <= instrF;
      pc_mem_r[tail_r]    <= pcF;
    end
  end

  // Head/tail pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r <= {PTR_W{1'b0}};
      tail_r <= {PTR_W{1'b0}};
      occ_r  <= {OCC_W{1'b0}};
    end else if (flushD) begin
      head_r <= {PTR_W{1'b0}};
      tail_r <= {PTR_W{1'b0}};
      occ_r  <= {OCC_W{1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Mode state register
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r <= RESET_MODE;
    end else begin
      mode_r <= mode_next_s;
    end
  end

  // Mode next state: flush loads flushArm, otherwise a switching pop flips it
  always_comb begin
    mode_next_s = mode_r;
    if (flushD) begin
      mode_next_s = flushArm ? MODE_ARM : MODE_RV;
    end else if (pop_s && switch_s) begin
      case (mode_r)
        MODE_RV:  mode_next_s = MODE_ARM;
        MODE_ARM: mode_next_s = MODE_RV;
        default:  mode_next_s = RESET_MODE;
      endcase
    end else begin
      mode_next_s = mode_r;
    end
  end

  // Saturating switch counter; pops during a flush do not count
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!flushD && pop_s && switch_s && (cnt_r != CNT_MAX_C)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign readyF      = ready_s;
  assign validD      = valid_s;
  assign instrD      = instr_mem_r[head_r];
  assign pcD         = pc_mem_r[head_r];
  assign armD        = arm_s;
  assign illegalD    = illegal_s;
  assign modeSwitchD = switch_s;
  assign occupancy   = occ_r;
  assign switchCount = cnt_r;

endmodule
